disp_stream_writer: RTL
=======================

# disp_stream_writer

Sink for the disparity stream produced by the stereo matching core. It takes the one-sample-per-strobe disparity output (no back-pressure available upstream), tracks column/row position within the frame, and packs samples into fixed-width words. It buffers those words in a small FIFO and presents them on a valid/ready output link with start-of-frame and end-of-frame markers, for a DMA or frame-buffer writer.

## Interface
Parameters:
- D, 64, disparity range; DBIT = $clog2(D), must be ≤ 8
- COLS, 450, disparity samples per line
- ROWS, 375, lines per frame
- W, 32, output word width; multiple of 8; P = W/8 lanes per word
- DEPTH, 16, FIFO depth in words; power of two, ≥ 2

Ports:
- i_clk  in  1  clock
- i_rstn  in  1  reset; asynchronous, active-low
- i_dval  in  1  disparity sample strobe
- i_data  in  DBIT  disparity sample
- i_soft_clr  in  1  synchronous resync: discard partial word, FIFO contents, position
- o_tvalid  out  1  output word valid
- i_tready  in  1  downstream accepts word
- o_tdata  out  W  packed word; lane k = bits [8k+7:8k], zero-extended sample
- o_tuser  out  1  word holds first sample of frame
- o_tlast  out  1  word holds last sample of frame
- o_overflow  out  1  sticky, a word was dropped on full FIFO
- o_frame_done  out  1  one-cycle pulse per completed frame
- o_frame_cnt  out  16  completed frames, wraps

## Operation
- Position counters col (0..COLS-1) and row (0..ROWS-1) advance on each i_dval; col wraps to 0 and increments row; row wraps to 0 at frame end.
- Pack register fills lane 0 first (LSBs); lane index advances per sample and wraps at P.
- Word push when lane P-1 is written, or when the sample is frame-last (col==COLS-1, row==ROWS-1). Partial words pad the unused lanes with zero.
- Lane index resets to 0 at frame end, so every frame starts word-aligned.
- A push carries tuser=1 if the word contains sample (0,0), and tlast=1 if it contains the frame-last sample. Both may be set when COLS*ROWS ≤ P.
- Push is accepted if FIFO count < DEPTH, or if a pop occurs in the same cycle.
  - Otherwise the word is dropped and o_overflow is set.
  - Counters still advance, so frame alignment is kept.
- Pop happens when o_tvalid & i_tready. o_tdata/o_tuser/o_tlast hold stable while o_tvalid=1 and i_tready=0.
- The frame-last sample increments o_frame_cnt and pulses o_frame_done, whether the word was pushed or dropped.
- i_soft_clr empties the FIFO, zeros the pack register, lane index, col, row and o_overflow. o_frame_cnt is kept. An i_dval in the same cycle is discarded.

## Timing
- Reset values: o_tvalid=0, o_tdata=0, o_tuser=0, o_tlast=0, o_overflow=0, o_frame_done=0, o_frame_cnt=0. All internal counters, pointers and the pack register are 0.
- Reset mid-frame drops everything; the next i_dval is sample (0,0).
- Push latency: sample completing a word in cycle t → word in FIFO at t+1. With the FIFO empty, o_tvalid=1 at t+1 (first-word fall-through, registered output).
- o_frame_done is asserted in cycle t+1 for a frame-last sample in cycle t. o_frame_cnt updates in the same cycle t+1.
- Sustained throughput is one sample per cycle. With i_tready=1 constantly, the FIFO never exceeds 1 word.
- Simultaneous push and pop with FIFO full: both happen and count is unchanged.
- Simultaneous push and pop with FIFO empty: word enters and o_tvalid rises the next cycle. No bypass in the same cycle.
- i_soft_clr in cycle t: o_tvalid=0 from t+1, and o_overflow=0 at t+1. A pop in cycle t still counts as a completed transfer.
- o_overflow is set in the cycle after the dropped push.

## Structure
- Shared package stereo_pkg:
  - LANE_W=8
  - a lane-count function P(W)
  - a clog2-based width helper for counters, shared with the other stereo blocks.
- One sub-module disp_fifo:
  - synchronous FIFO, width W+2 (data, tuser, tlast), depth DEPTH
  - first-word-fall-through with registered output, and a count output
  - synchronous clear
- Top level holds position counters, packer, push/drop logic and frame statistics.

## Test plan
- Baseline, COLS=4, ROWS=2, W=32, i_tready=1: samples 1..8 on consecutive cycles → words 0x04030201 (tuser=1) and 0x08070605 (tlast=1). o_frame_done pulses once and o_frame_cnt=1.
- Partial flush, COLS=3, ROWS=2: samples 1..6 → 0x04030201 (tuser) and 0x00000605 (tlast). The next frame's first word starts at lane 0.
- Back-pressure, i_tready=0 for 20 cycles, DEPTH=4, 24 samples (6 words): 4 words retained and 2 dropped, o_overflow=1. On release, 4 words drain in order and o_frame_cnt still counts the frame.
- Full FIFO with simultaneous push and pop, i_tready toggled each cycle at count=DEPTH: no drop and o_overflow stays 0.
- i_soft_clr mid-line after 5 samples: o_tvalid=0 next cycle, FIFO empty. The following samples restart at (0,0) with tuser=1, and o_frame_cnt is unchanged.
- Async reset asserted with FIFO holding 3 words: all outputs go to 0 immediately. After reset release, the first word has tuser=1.

Source files
------------

// File: rtl/stereo_pkg.sv
// -----------------------------------------------------------------------------
// stereo_pkg
// Shared constants and width helpers for the stereo pipeline blocks.
//   LANE_W      : width of one byte lane in packed output words
//   lane_count  : number of byte lanes in a word of width w
//   cnt_width   : bits needed for a counter spanning 0..n-1 (minimum 1)
// -----------------------------------------------------------------------------
package stereo_pkg;

   localparam int LANE_W = 8;

   function automatic int lane_count(input int w);
      return w / LANE_W;
   endfunction

   function automatic int cnt_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/disp_fifo.sv
// -----------------------------------------------------------------------------
// disp_fifo
// Synchronous first-word-fall-through FIFO with a registered output stage.
// The head word is always present on o_rdata while o_valid is high; a word
// written into an empty FIFO appears on the output one cycle later.
//
// Ports:
//   i_clk, i_rstn : clock, asynchronous active-low reset
//   i_clr         : synchronous clear (drops all contents)
//   i_push        : write i_wdata (ignored when full and not popping)
//   i_wdata       : write data, DW bits
//   i_pop         : consume the head word (ignored when empty)
//   o_valid       : head word valid
//   o_rdata       : head word, held stable until popped
//   o_count       : number of stored words, 0..DEPTH
// -----------------------------------------------------------------------------
module disp_fifo
   import stereo_pkg::*;
#(
   parameter int DW    = 34,
   parameter int DEPTH = 16,
   localparam int AW   = cnt_width(DEPTH),
   localparam int CW   = cnt_width(DEPTH + 1)
)(
   input  logic          i_clk,
   input  logic          i_rstn,
   input  logic          i_clr,
   input  logic          i_push,
   input  logic [DW-1:0] i_wdata,
   input  logic          i_pop,
   output logic          o_valid,
   output logic [DW-1:0] o_rdata,
   output logic [CW-1:0] o_count
);

   localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

   logic [DW-1:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr_q, rd_ptr_q, rd_next;
   logic [CW-1:0] count_q, cnt_after_pop, count_d;
   logic [DW-1:0] rdata_q, rdata_d;
   logic          valid_q, valid_d;
   logic          push_en, pop_en;

   assign pop_en  = i_pop & valid_q;
   assign push_en = i_push & ((count_q != CNT_FULL) | pop_en);

   // NOTE: every signal assigned in always_comb gets a default on entry, so
   // no path leaves it unassigned and no latch is inferred.
   always_comb begin
      cnt_after_pop = count_q - CW'(pop_en);
      count_d       = cnt_after_pop + CW'(push_en);
      rd_next       = rd_ptr_q + AW'(pop_en);
      valid_d       = (count_d != '0);
      rdata_d       = rdata_q;
      // When the incoming word becomes the head it has not reached memory
      // yet, so it is routed straight into the output register.
      if (push_en && (cnt_after_pop == '0)) begin
         rdata_d = i_wdata;
      end else if (count_d != '0) begin
         rdata_d = mem[rd_next];
      end
   end

   // NOTE: storage array has no reset; it is only read behind a valid count,
   // and leaving it unreset lets it map onto plain RAM.
   always_ff @(posedge i_clk) begin
      if (push_en) begin
         mem[wr_ptr_q] <= i_wdata;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         rdata_q  <= '0;
         valid_q  <= 1'b0;
      end else if (i_clr) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         rdata_q  <= '0;
         valid_q  <= 1'b0;
      end else begin
         if (push_en) begin
            wr_ptr_q <= wr_ptr_q + AW'(1);
         end
         rd_ptr_q <= rd_next;
         count_q  <= count_d;
         rdata_q  <= rdata_d;
         valid_q  <= valid_d;
      end
   end

   assign o_valid = valid_q;
   assign o_rdata = rdata_q;
   assign o_count = count_q;

endmodule

// File: rtl/disp_stream_writer.sv
// -----------------------------------------------------------------------------
// disp_stream_writer
// Sink for the disparity stream. Tracks column/row within the frame, packs
// zero-extended samples into W-bit words (lane 0 first), buffers them in a
// FWFT FIFO and presents them on a valid/ready link with frame markers.
//
// Ports:
//   i_clk, i_rstn  : clock, asynchronous active-low reset
//   i_dval, i_data : disparity sample strobe and value (DBIT bits)
//   i_soft_clr     : synchronous resync; drops partial word, FIFO, position
//   o_tvalid       : output word valid
//   i_tready       : downstream accepts word
//   o_tdata        : packed word, lane k = bits [8k+7:8k]
//   o_tuser        : word holds the first sample of a frame
//   o_tlast        : word holds the last sample of a frame
//   o_overflow     : sticky, a word was dropped on a full FIFO
//   o_frame_done   : one-cycle pulse per completed frame
//   o_frame_cnt    : completed frame counter, wraps
// -----------------------------------------------------------------------------
module disp_stream_writer
   import stereo_pkg::*;
#(
   parameter int D      = 64,
   parameter int COLS   = 450,
   parameter int ROWS   = 375,
   parameter int W      = 32,
   parameter int DEPTH  = 16,
   localparam int DBIT  = $clog2(D)
)(
   input  logic            i_clk,
   input  logic            i_rstn,
   input  logic            i_dval,
   input  logic [DBIT-1:0] i_data,
   input  logic            i_soft_clr,
   output logic            o_tvalid,
   input  logic            i_tready,
   output logic [W-1:0]    o_tdata,
   output logic            o_tuser,
   output logic            o_tlast,
   output logic            o_overflow,
   output logic            o_frame_done,
   output logic [15:0]     o_frame_cnt
);

   localparam int P       = lane_count(W);
   localparam int COL_W   = cnt_width(COLS);
   localparam int ROW_W   = cnt_width(ROWS);
   localparam int LANE_IW = cnt_width(P);
   localparam int CNT_W   = cnt_width(DEPTH + 1);
   localparam int FW      = W + 2;

   localparam logic [COL_W-1:0]   COL_LAST  = COL_W'(COLS - 1);
   localparam logic [ROW_W-1:0]   ROW_LAST  = ROW_W'(ROWS - 1);
   localparam logic [LANE_IW-1:0] LANE_LAST = LANE_IW'(P - 1);
   localparam logic [CNT_W-1:0]   CNT_FULL  = CNT_W'(DEPTH);

   logic [COL_W-1:0]   col_q;
   logic [ROW_W-1:0]   row_q;
   logic [LANE_IW-1:0] lane_q;
   logic [W-1:0]       pack_q, pack_next;
   logic               sof_q;
   logic               ovf_q;
   logic               done_q;
   logic [15:0]        fcnt_q;

   logic               sample, at_first, at_last, word_end;
   logic               push_req, push_ok, drop, pop;
   logic [FW-1:0]      push_word, fifo_rdata;
   logic [CNT_W-1:0]   fifo_count;
   logic               fifo_valid;

   // A strobe coinciding with a resync is discarded.
   assign sample   = i_dval & ~i_soft_clr;
   assign at_first = (col_q == '0) && (row_q == '0);
   assign at_last  = (col_q == COL_LAST) && (row_q == ROW_LAST);
   assign word_end = (lane_q == LANE_LAST) || at_last;

   assign pop      = fifo_valid & i_tready;
   assign push_req = sample & word_end;
   assign push_ok  = push_req & ((fifo_count != CNT_FULL) | pop);
   assign drop     = push_req & ~push_ok;

   // Current pack register with the incoming sample dropped into its lane.
   // Lanes above the write lane are still zero, which pads partial words.
   always_comb begin
      pack_next = pack_q;
      for (int k = 0; k < P; k++) begin
         if (lane_q == LANE_IW'(k)) begin
            pack_next[k*LANE_W +: LANE_W] = LANE_W'(i_data);
         end
      end
   end

   assign push_word = {at_last, sof_q | at_first, pack_next};

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         col_q  <= '0;
         row_q  <= '0;
         lane_q <= '0;
         pack_q <= '0;
         sof_q  <= 1'b0;
         ovf_q  <= 1'b0;
         done_q <= 1'b0;
         fcnt_q <= '0;
      end else if (i_soft_clr) begin
         // Frame counter survives a resync.
         col_q  <= '0;
         row_q  <= '0;
         lane_q <= '0;
         pack_q <= '0;
         sof_q  <= 1'b0;
         ovf_q  <= 1'b0;
         done_q <= 1'b0;
      end else begin
         done_q <= sample & at_last;
         if (drop) begin
            ovf_q <= 1'b1;
         end
         if (sample) begin
            // Position advances even for dropped words to keep alignment.
            if (col_q == COL_LAST) begin
               col_q <= '0;
               row_q <= (row_q == ROW_LAST) ? '0 : row_q + ROW_W'(1);
            end else begin
               col_q <= col_q + COL_W'(1);
            end
            // Word boundary also at frame end, so each frame starts at lane 0.
            if (word_end) begin
               lane_q <= '0;
               pack_q <= '0;
               sof_q  <= 1'b0;
            end else begin
               lane_q <= lane_q + LANE_IW'(1);
               pack_q <= pack_next;
               sof_q  <= sof_q | at_first;
            end
            if (at_last) begin
               fcnt_q <= fcnt_q + 16'd1;
            end
         end
      end
   end

   disp_fifo #(
      .DW    (FW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .i_clk   (i_clk),
      .i_rstn  (i_rstn),
      .i_clr   (i_soft_clr),
      .i_push  (push_ok),
      .i_wdata (push_word),
      .i_pop   (pop),
      .o_valid (fifo_valid),
      .o_rdata (fifo_rdata),
      .o_count (fifo_count)
   );

   assign o_tvalid     = fifo_valid;
   assign o_tdata      = fifo_rdata[W-1:0];
   assign o_tuser      = fifo_rdata[W];
   assign o_tlast      = fifo_rdata[W+1];
   assign o_overflow   = ovf_q;
   assign o_frame_done = done_q;
   assign o_frame_cnt  = fcnt_q;

endmodule
